pipe_ctrl_unit: RTL and testbench
=================================

Name: pipe_ctrl_unit

Overview:
Control unit for the 5-stage MIPS pipeline. It decodes the ID-stage opcode/funct into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It also owns hazard handling: load-use stall, jump/branch flush, and a parametrised multi-cycle MULTU stall. It sits beside the datapath and drives PC/IF-ID enables plus the per-stage control signals.

Parameters:
MULT_CYCLES, 32, cycles MULTU occupies EX (>=1)
EN_MULT, 1, 0 = MULTU decodes as illegal
REG_AW, 5, register-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_opcode  in  6  opcode of instruction in IF/ID
id_funct  in  6  funct field of IF/ID
id_rs  in  REG_AW  rs of IF/ID
id_rt  in  REG_AW  rt of IF/ID
branch_taken  in  1  MEM-stage branch & zero, resolved this cycle
pc_write  out  1  PC enable
if_id_write  out  1  IF/ID enable
if_id_flush  out  1  zero IF/ID next edge
jump_id  out  1  J decoded in ID and issuing (selects jump target)
ex_reg_dst, ex_alu_src  out  1 each  EX controls
ex_alu_op  out  2  EX ALUOp
ex_rt  out  REG_AW  rt latched with ID/EX
mult_start  out  1  one-cycle pulse to the multiplier
mult_busy  out  1  multiply stall in progress
mem_read, mem_write, mem_branch  out  1 each  MEM controls
wb_reg_write, wb_mem_to_reg  out  1 each  WB controls
illegal_instr  out  1  registered pulse; unknown opcode entered ID/EX

Behaviour:
- Reset (rst high at edge): every stage register, ex_rt, the counter and illegal_instr go to 0. pc_write=1, if_id_write=1, if_id_flush=0, mult_start=0, mult_busy=0. Reset overrides all other events.
- Decode table (ALUOp R=10, BEQ=01, else 00):
  - R (0), funct!=0: RegDst 1, RegWrite 1.
  - ADDIU (9): ALUSrc 1, RegWrite 1.
  - LW (35): ALUSrc 1, MemtoReg 1, RegWrite 1, MemRead 1.
  - SW (43): ALUSrc 1, MemWrite 1.
  - BEQ (4): Branch 1.
  - J (2): bubble in the pipe; asserts jump_id.
  - MULTU (R, funct 25, EN_MULT=1): bubble controls, arms the multiply stall.
  - NOP (R, funct 0), unknown opcodes: all controls 0, never x. An unknown opcode also sets illegal_instr for one cycle after it is captured.
- Stage advance: each edge, ID/EX<=decode, EX/MEM<=ID/EX, MEM/WB<=EX/MEM, unless modified below. Outputs come straight from the stage registers (1-cycle latency per stage).
- Priority: branch_taken > multiply stall > load-use stall > jump > normal.
- branch_taken: IF/ID flushed (if_id_flush=1), ID/EX and EX/MEM loaded with bubble. Counter cleared, so an in-flight MULTU is aborted: mult_busy=0 next cycle, no further mult_start. pc_write=1.
- Multiply: when MULTU is captured into ID/EX, the counter loads MULT_CYCLES-1 and mult_start pulses in the following cycle (MULTU in EX).
  - While counter!=0: pc_write=0, if_id_write=0, ID/EX held, EX/MEM gets bubble, counter decrements, mult_busy=1.
  - MULT_CYCLES=1 gives no stall.
- Load-use: ID/EX.MemRead && (ex_rt==id_rs || (ex_rt==id_rt && ID uses rt: R, SW, BEQ)).
  - Effect: pc_write=0, if_id_write=0, ID/EX<=bubble for one cycle.
  - ex_rt==0 still stalls; no $zero special case.
- Jump: jump_id=1 and if_id_flush=1 only when not stalled. A jump waiting behind a stall is held in ID and flushes on the release cycle.
- Combinational outputs: pc_write, if_id_write, if_id_flush, jump_id, mult_start, mult_busy. All others are registered.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - opcode/funct constants (R_FORMAT, ADDIU, LW, SW, BEQ, J, FUNCT_MULTU)
  - ALUOp encodings
  - control-bundle field widths/offsets, and the BUBBLE constant (all zeros)
- Sub-module ctrl_decode: purely combinational opcode/funct -> bundle + is_jump/is_multu/is_illegal/uses_rt.

Test Plan:
- rst high 2 cycles with opcode=35 driven -> all stage outputs 0, pc_write=1, mult_busy=0; first edge after release captures LW (ex_alu_src=1).
- LW rt=8, then ADD rs=8 -> one cycle pc_write=0, if_id_write=0, ID/EX bubble; next cycle ADD in EX with ex_reg_dst=1, ex_alu_op=10.
- MULTU, MULT_CYCLES=4 -> mult_start high 1 cycle; mult_busy and pc_write=0 for 3 cycles; 3 bubbles in MEM; following instruction enters EX the cycle after busy drops.
- MULTU stalled, branch_taken=1 on 2nd busy cycle -> if_id_flush=1, mult_busy=0 next cycle, ex_*/mem_* controls 0.
- opcode=63 -> ID/EX controls 0, illegal_instr=1 exactly one cycle; instr 0x00000000 -> controls 0, illegal_instr=0.
- J behind a load-use stall -> jump_id=0 during stall, then jump_id=1 and if_id_flush=1 for exactly one cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: MIPS opcode/funct values,
// ALUOp codes and the layout of the packed control bundle.
package pipe_ctrl_pkg;

  localparam logic [5:0] R_FORMAT    = 6'd0;
  localparam logic [5:0] J           = 6'd2;
  localparam logic [5:0] BEQ         = 6'd4;
  localparam logic [5:0] ADDIU       = 6'd9;
  localparam logic [5:0] LW          = 6'd35;
  localparam logic [5:0] SW          = 6'd43;
  localparam logic [5:0] FUNCT_NOP   = 6'd0;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  // Bundle layout, low to high: WB fields, then MEM fields, then EX fields,
  // so each later stage register keeps only a low slice of the bundle.
  localparam int CB_MEM_TO_REG = 0;
  localparam int CB_REG_WRITE  = 1;
  localparam int CB_BRANCH     = 2;
  localparam int CB_MEM_WRITE  = 3;
  localparam int CB_MEM_READ   = 4;
  localparam int CB_ALU_OP     = 5;
  localparam int CB_ALU_SRC    = 7;
  localparam int CB_REG_DST    = 8;

  localparam int WB_W    = 2;
  localparam int EXMEM_W = 5;
  localparam int CTRL_W  = 9;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  function automatic ctrl_t mk_ctrl(input logic reg_dst, input logic alu_src,
                                    input logic [1:0] alu_op, input logic mem_read,
                                    input logic mem_write, input logic branch,
                                    input logic reg_write, input logic mem_to_reg);
    return {reg_dst, alu_src, alu_op, mem_read, mem_write, branch, reg_write, mem_to_reg};
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational ID-stage decoder: opcode/funct to control bundle plus the
// hazard-relevant instruction class flags.
module ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int EN_MULT = 1
) (
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_is_jump,
  output logic       o_is_multu,
  output logic       o_is_illegal,
  output logic       o_uses_rt
);

  // Decode table; anything unrecognised yields an all-zero bundle
  always_comb begin
    o_ctrl       = BUBBLE;
    o_is_jump    = 1'b0;
    o_is_multu   = 1'b0;
    o_is_illegal = 1'b0;
    o_uses_rt    = 1'b0;
    case (i_opcode)
      R_FORMAT: begin
        o_uses_rt = 1'b1;
        if (i_funct == FUNCT_MULTU) begin
          if (EN_MULT != 0) o_is_multu   = 1'b1;
          else              o_is_illegal = 1'b1;
        end else if (i_funct != FUNCT_NOP) begin
          o_ctrl = mk_ctrl(1'b1, 1'b0, ALUOP_R, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
      end
      ADDIU:   o_ctrl = mk_ctrl(1'b0, 1'b1, ALUOP_ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      LW:      o_ctrl = mk_ctrl(1'b0, 1'b1, ALUOP_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      SW: begin
        o_ctrl    = mk_ctrl(1'b0, 1'b1, ALUOP_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        o_uses_rt = 1'b1;
      end
      BEQ: begin
        o_ctrl    = mk_ctrl(1'b0, 1'b0, ALUOP_SUB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        o_uses_rt = 1'b1;
      end
      J:       o_is_jump    = 1'b1;
      default: o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit: decodes ID, carries controls through ID/EX, EX/MEM
// and MEM/WB, and resolves branch flush, multiply stall, load-use stall and
// jump redirect in that priority order.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int EN_MULT     = 1,
  parameter int REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        id_opcode,
  input  logic [5:0]        id_funct,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              jump_id,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rt,
  output logic              mult_start,
  output logic              mult_busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_branch,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              illegal_instr
);

  localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

  ctrl_t              w_dec_ctrl;
  logic               w_is_jump, w_is_multu, w_is_illegal, w_uses_rt;
  ctrl_t              r_ctrl_p0, w_ctrl_p0_nxt;
  logic [EXMEM_W-1:0] r_ctrl_p1, w_ctrl_p1_nxt;
  logic [WB_W-1:0]    r_ctrl_p2;
  logic [REG_AW-1:0]  r_ex_rt, w_ex_rt_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_mult_first, w_mult_first_nxt;
  logic               r_illegal, w_illegal_nxt;
  logic               w_mult_stall, w_load_use;

  ctrl_decode #(.EN_MULT(EN_MULT)) u_decode (
    .i_opcode     (id_opcode),
    .i_funct      (id_funct),
    .o_ctrl       (w_dec_ctrl),
    .o_is_jump    (w_is_jump),
    .o_is_multu   (w_is_multu),
    .o_is_illegal (w_is_illegal),
    .o_uses_rt    (w_uses_rt)
  );

  assign w_mult_stall = (r_cnt != '0);
  assign w_load_use   = r_ctrl_p0[CB_MEM_READ] &&
                        ((r_ex_rt == id_rs) || (w_uses_rt && (r_ex_rt == id_rt)));

  // Hazard arbitration and next-state selection for every stage register
  always_comb begin
    pc_write         = 1'b1;
    if_id_write      = 1'b1;
    if_id_flush      = 1'b0;
    jump_id          = 1'b0;
    mult_busy        = w_mult_stall;
    mult_start       = r_mult_first;
    w_ctrl_p0_nxt    = w_dec_ctrl;
    w_ex_rt_nxt      = id_rt;
    w_ctrl_p1_nxt    = r_ctrl_p0[EXMEM_W-1:0];
    w_cnt_nxt        = w_is_multu ? CNT_LOAD : '0;
    w_mult_first_nxt = w_is_multu;
    w_illegal_nxt    = w_is_illegal;
    if (rst) begin
      mult_busy  = 1'b0;
      mult_start = 1'b0;
    end else if (branch_taken) begin
      if_id_flush      = 1'b1;
      mult_start       = 1'b0;
      w_ctrl_p0_nxt    = BUBBLE;
      w_ex_rt_nxt      = '0;
      w_ctrl_p1_nxt    = '0;
      w_cnt_nxt        = '0;
      w_mult_first_nxt = 1'b0;
      w_illegal_nxt    = 1'b0;
    end else if (w_mult_stall) begin
      pc_write         = 1'b0;
      if_id_write      = 1'b0;
      w_ctrl_p0_nxt    = r_ctrl_p0;
      w_ex_rt_nxt      = r_ex_rt;
      w_ctrl_p1_nxt    = '0;
      w_cnt_nxt        = r_cnt - CNT_W'(1);
      w_mult_first_nxt = 1'b0;
      w_illegal_nxt    = 1'b0;
    end else if (w_load_use) begin
      pc_write         = 1'b0;
      if_id_write      = 1'b0;
      w_ctrl_p0_nxt    = BUBBLE;
      w_ex_rt_nxt      = '0;
      w_cnt_nxt        = '0;
      w_mult_first_nxt = 1'b0;
      w_illegal_nxt    = 1'b0;
    end else if (w_is_jump) begin
      jump_id     = 1'b1;
      if_id_flush = 1'b1;
    end
  end

  // Stage registers: ID/EX (_p0), EX/MEM (_p1), MEM/WB (_p2) plus stall state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl_p0    <= BUBBLE;
      r_ctrl_p1    <= '0;
      r_ctrl_p2    <= '0;
      r_ex_rt      <= '0;
      r_cnt        <= '0;
      r_mult_first <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_ctrl_p0    <= w_ctrl_p0_nxt;
      r_ctrl_p1    <= w_ctrl_p1_nxt;
      r_ctrl_p2    <= r_ctrl_p1[WB_W-1:0];
      r_ex_rt      <= w_ex_rt_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mult_first <= w_mult_first_nxt;
      r_illegal    <= w_illegal_nxt;
    end
  end

  assign ex_reg_dst    = r_ctrl_p0[CB_REG_DST];
  assign ex_alu_src    = r_ctrl_p0[CB_ALU_SRC];
  assign ex_alu_op     = r_ctrl_p0[CB_ALU_OP +: 2];
  assign ex_rt         = r_ex_rt;
  assign mem_read      = r_ctrl_p1[CB_MEM_READ];
  assign mem_write     = r_ctrl_p1[CB_MEM_WRITE];
  assign mem_branch    = r_ctrl_p1[CB_BRANCH];
  assign wb_reg_write  = r_ctrl_p2[CB_REG_WRITE];
  assign wb_mem_to_reg = r_ctrl_p2[CB_MEM_TO_REG];
  assign illegal_instr = r_illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit with MULT_CYCLES=4.
module tb_pipe_ctrl_unit;

  logic       clk;
  logic       rst;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt;
  logic       branch_taken;
  logic       pc_write, if_id_write, if_id_flush, jump_id;
  logic       ex_reg_dst, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rt;
  logic       mult_start, mult_busy;
  logic       mem_read, mem_write, mem_branch;
  logic       wb_reg_write, wb_mem_to_reg, illegal_instr;

  int n_pass  = 0;
  int n_total = 0;

  // {pc_write, if_id_write, if_id_flush, jump_id, mult_start, mult_busy}
  logic [5:0] hz;
  logic [3:0] ex_f;
  logic [2:0] mem_f;
  logic [1:0] wb_f;
  assign hz    = {pc_write, if_id_write, if_id_flush, jump_id, mult_start, mult_busy};
  assign ex_f  = {ex_reg_dst, ex_alu_src, ex_alu_op};
  assign mem_f = {mem_read, mem_write, mem_branch};
  assign wb_f  = {wb_reg_write, wb_mem_to_reg};

  // ADD, ADDIU, LW, SW, BEQ with their expected EX/MEM/WB control fields
  logic [5:0] dec_op  [5] = '{6'd0, 6'd9, 6'd35, 6'd43, 6'd4};
  logic [5:0] dec_fn  [5] = '{6'd32, 6'd0, 6'd0, 6'd0, 6'd0};
  logic [4:0] dec_rs  [5] = '{5'd3, 5'd5, 5'd9, 5'd11, 5'd13};
  logic [4:0] dec_rt  [5] = '{5'd4, 5'd6, 5'd10, 5'd12, 5'd14};
  logic [3:0] exp_ex  [5] = '{4'b1010, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
  logic [2:0] exp_mem [5] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b001};
  logic [1:0] exp_wb  [5] = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b00};

  pipe_ctrl_unit #(.MULT_CYCLES(4), .EN_MULT(1), .REG_AW(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_opcode     (id_opcode),
    .id_funct      (id_funct),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .branch_taken  (branch_taken),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .if_id_flush   (if_id_flush),
    .jump_id       (jump_id),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op),
    .ex_rt         (ex_rt),
    .mult_start    (mult_start),
    .mult_busy     (mult_busy),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_branch    (mem_branch),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .illegal_instr (illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [4:0] rs, input logic [4:0] rt);
    id_opcode = op;
    id_funct  = fn;
    id_rs     = rs;
    id_rt     = rt;
    #1;
  endtask

  task automatic drain();
    set_instr(6'd0, 6'd0, 5'd0, 5'd0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    branch_taken = 1'b0;
    set_instr(6'd35, 6'd0, 5'd1, 5'd2);
    tick();
    tick();
    n_total++;
    if ({ex_f, mem_f, wb_f} !== 9'd0) $display("FAIL reset_stages got %b want 0", {ex_f, mem_f, wb_f});
    else n_pass++;
    n_total++;
    if (hz !== 6'b110000) $display("FAIL reset_hz got %b want 110000", hz);
    else n_pass++;
    n_total++;
    if ({illegal_instr, ex_rt} !== 6'd0) $display("FAIL reset_misc got %b want 0", {illegal_instr, ex_rt});
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if ({ex_alu_src, ex_rt} !== {1'b1, 5'd2}) $display("FAIL reset_first_lw got %b want 1_00010", {ex_alu_src, ex_rt});
    else n_pass++;
  endtask

  task automatic test_decode();
    drain();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_instr(dec_op[i], dec_fn[i], dec_rs[i], dec_rt[i]);
      else       set_instr(6'd0, 6'd0, 5'd0, 5'd0);
      tick();
      if (i < 5) begin
        n_total++;
        if (ex_f !== exp_ex[i]) $display("FAIL decode_ex[%0d] got %b want %b", i, ex_f, exp_ex[i]);
        else n_pass++;
      end
      if (i >= 1 && i <= 5) begin
        n_total++;
        if (mem_f !== exp_mem[i-1]) $display("FAIL decode_mem[%0d] got %b want %b", i-1, mem_f, exp_mem[i-1]);
        else n_pass++;
      end
      if (i >= 2) begin
        n_total++;
        if (wb_f !== exp_wb[i-2]) $display("FAIL decode_wb[%0d] got %b want %b", i-2, wb_f, exp_wb[i-2]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_load_use();
    drain();
    set_instr(6'd35, 6'd0, 5'd1, 5'd8);
    tick();
    set_instr(6'd0, 6'd32, 5'd8, 5'd9);
    n_total++;
    if (hz !== 6'b000000) $display("FAIL loaduse_stall got %b want 000000", hz);
    else n_pass++;
    tick();
    n_total++;
    if ({ex_f, mem_read} !== 5'b00001) $display("FAIL loaduse_bubble got %b want 00001", {ex_f, mem_read});
    else n_pass++;
    n_total++;
    if (hz !== 6'b110000) $display("FAIL loaduse_release got %b want 110000", hz);
    else n_pass++;
    tick();
    n_total++;
    if (ex_f !== 4'b1010) $display("FAIL loaduse_add_ex got %b want 1010", ex_f);
    else n_pass++;
    drain();
    set_instr(6'd35, 6'd0, 5'd1, 5'd0);
    tick();
    set_instr(6'd0, 6'd32, 5'd0, 5'd5);
    n_total++;
    if (pc_write !== 1'b0) $display("FAIL loaduse_zero_reg got %b want 0", pc_write);
    else n_pass++;
    tick();
  endtask

  task automatic test_mult();
    drain();
    set_instr(6'd0, 6'd25, 5'd5, 5'd6);
    tick();
    set_instr(6'd9, 6'd0, 5'd7, 5'd7);
    n_total++;
    if (hz !== 6'b000011) $display("FAIL mult_first got %b want 000011", hz);
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_total++;
      if ({hz, mem_f} !== 9'b000001_000) $display("FAIL mult_busy[%0d] got %b want 000001000", k, {hz, mem_f});
      else n_pass++;
    end
    tick();
    n_total++;
    if ({hz, ex_f} !== 10'b110000_0000) $display("FAIL mult_done got %b want 1100000000", {hz, ex_f});
    else n_pass++;
    tick();
    n_total++;
    if (ex_f !== 4'b0100) $display("FAIL mult_next_ex got %b want 0100", ex_f);
    else n_pass++;
  endtask

  task automatic test_mult_abort();
    drain();
    set_instr(6'd0, 6'd25, 5'd5, 5'd6);
    tick();
    set_instr(6'd9, 6'd0, 5'd7, 5'd7);
    tick();
    branch_taken = 1'b1;
    #1;
    n_total++;
    if (hz !== 6'b111001 && hz !== 6'b101001) $display("FAIL abort_branch got %b want 1x1001", hz);
    else n_pass++;
    tick();
    branch_taken = 1'b0;
    set_instr(6'd0, 6'd0, 5'd0, 5'd0);
    n_total++;
    if ({hz, ex_f, mem_f} !== 13'b110000_0000_000) $display("FAIL abort_after got %b want 1100000000000", {hz, ex_f, mem_f});
    else n_pass++;
    tick();
    n_total++;
    if ({mult_start, mult_busy} !== 2'b00) $display("FAIL abort_quiet got %b want 00", {mult_start, mult_busy});
    else n_pass++;
  endtask

  task automatic test_illegal();
    drain();
    set_instr(6'd63, 6'd0, 5'd0, 5'd0);
    tick();
    n_total++;
    if ({illegal_instr, ex_f} !== 5'b10000) $display("FAIL illegal_set got %b want 10000", {illegal_instr, ex_f});
    else n_pass++;
    set_instr(6'd0, 6'd0, 5'd0, 5'd0);
    tick();
    n_total++;
    if ({illegal_instr, ex_f} !== 5'b00000) $display("FAIL illegal_nop got %b want 00000", {illegal_instr, ex_f});
    else n_pass++;
  endtask

  task automatic test_jump_stall();
    drain();
    set_instr(6'd35, 6'd0, 5'd1, 5'd8);
    tick();
    set_instr(6'd2, 6'd0, 5'd8, 5'd3);
    n_total++;
    if (hz !== 6'b000000) $display("FAIL jump_stalled got %b want 000000", hz);
    else n_pass++;
    tick();
    n_total++;
    if (hz !== 6'b111100) $display("FAIL jump_release got %b want 111100", hz);
    else n_pass++;
    tick();
    set_instr(6'd0, 6'd0, 5'd0, 5'd0);
    n_total++;
    if ({hz, ex_f} !== 10'b110000_0000) $display("FAIL jump_once got %b want 1100000000", {hz, ex_f});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_mult();
    test_mult_abort();
    test_illegal();
    test_jump_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
